// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// board-default timing constants and the input polarity helper.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  // 10 ms of stability at the 100 MHz board clock
  localparam int unsigned DEFAULT_STABLE_COUNT = 32'd1000000;
  localparam int unsigned DEFAULT_CNT_WIDTH    = 32'd20;

  function automatic logic normalise_level(input logic raw, input logic active_low);
    return raw ^ active_low;
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button pin in, debounced level and edge strobes out.
interface button_debounce_if;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;

  modport master (output btn_in, input btn_level, input btn_rise, input btn_fall);
  modport slave  (input btn_in, output btn_level, output btn_rise, output btn_fall);
endinterface

// File: rtl/button_debounce_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_r;

  // Metastability filter: two back-to-back flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r <= 1'b0;
      q    <= 1'b0;
    end else begin
      s1_r <= d;
      q    <= s1_r;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: polarity normalise, synchronize, then accept a new
// level only after STABLE_COUNT qualifying cycles; emits rise/fall strobes.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int unsigned CNT_WIDTH    = DEFAULT_CNT_WIDTH,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  button_debounce_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 32'd1);

  logic                 btn_n_s;
  logic                 sync_s;
  db_state_t            state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 level_r;
  logic                 rise_r;
  logic                 fall_r;

  assign btn_n_s = normalise_level(bus.btn_in, ACTIVE_LOW);

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_n_s),
    .q     (sync_s)
  );

  // Qualification FSM; the counter stops at CNT_LAST so it never wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE_LO;
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        IDLE_LO: begin
          if (sync_s) begin
            state_r <= WAIT_HI;
            cnt_r   <= CNT_ZERO;
          end
        end
        WAIT_HI: begin
          if (!sync_s) begin
            state_r <= IDLE_LO;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= IDLE_HI;
            level_r <= 1'b1;
            rise_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!sync_s) begin
            state_r <= WAIT_LO;
            cnt_r   <= CNT_ZERO;
          end
        end
        WAIT_LO: begin
          if (sync_s) begin
            state_r <= IDLE_HI;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= IDLE_LO;
            level_r <= 1'b0;
            fall_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE_LO;
          cnt_r   <= CNT_ZERO;
          level_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_level = level_r;
  assign bus.btn_rise  = rise_r;
  assign bus.btn_fall  = fall_r;

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions a raw Mimas V2 push-button or DIP-switch input into a clean, clock-synchronous level for the downstream sequential stages (D flip-flop `d` inputs, counters, enables).
- Structure: two-flop synchronizer, then a counter-qualified state machine. A new level is accepted only after it has been stable for STABLE_COUNT cycles.
- Also emits one-cycle rise and fall strobes, so consumers need no edge detector of their own.

Parameters:
- STABLE_COUNT, 1000000, consecutive qualifying cycles required to accept a new level (10 ms at 100 MHz); legal range ≥1.
- CNT_WIDTH, 20, qualification counter width; must satisfy 2^CNT_WIDTH ≥ STABLE_COUNT.
- ACTIVE_LOW, 1, 1 = raw input is asserted when 0 (Mimas V2 buttons); 0 = asserted when 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
- btn_in  input  1  raw, asynchronous, bouncing button/switch pin.
- btn_level  output  1  debounced level; 1 = button pressed (polarity already normalised).
- btn_rise  output  1  one-cycle strobe on the edge where btn_level goes 0→1.
- btn_fall  output  1  one-cycle strobe on the edge where btn_level goes 1→0.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is asynchronous and active-high.
- Polarity:
  - btn_n = btn_in XOR ACTIVE_LOW, applied combinationally before the synchronizer.
  - All internal logic works on "pressed = 1".
- Synchronizer:
  - s1 <= btn_n; s2 <= s1.
  - Both reset to 0. Only s2 feeds the FSM.
- FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO. Reset state is IDLE_LO.
- IDLE_LO:
  - s2=1 → WAIT_HI, cnt <= 0.
  - Otherwise stay.
- WAIT_HI:
  - s2=0 → IDLE_LO (bounce; counter abandoned).
  - Else if cnt == STABLE_COUNT-1 → IDLE_HI, btn_level <= 1, btn_rise <= 1.
  - Else cnt <= cnt+1.
- IDLE_HI / WAIT_LO: mirror images of IDLE_LO / WAIT_HI, with s2=0 qualifying. On completion: btn_level <= 0, btn_fall <= 1.
- Outputs:
  - All registered. btn_rise and btn_fall default to 0 every cycle and are high for exactly one cycle.
  - Each strobe coincides with the first cycle of the new btn_level value.
  - btn_rise and btn_fall are never high together.
- Latency:
  - Raw input changes before edge E1 and stays stable.
  - btn_level changes, and the strobe fires, at edge E(STABLE_COUNT+3).
  - Breakdown: 2 edges of synchronizer, 1 edge to enter WAIT, STABLE_COUNT edges of counting.
- Bounce: any reversion of s2 during WAIT_x returns to the prior IDLE state. Qualification restarts from the next change.
- Glitch: a pulse shorter than STABLE_COUNT+1 cycles at s2 produces no output change and no strobe.
- Counter:
  - Unsigned, CNT_WIDTH bits; never wraps, because it stops at STABLE_COUNT-1.
  - Value is don't-care outside the WAIT states.
- Reset reset=1:
  - Output values: btn_level=0, btn_rise=0, btn_fall=0.
  - Internal values: s1=s2=0, cnt=0, state=IDLE_LO. All take effect immediately, independent of clk.
- Reset mid-operation: an in-progress qualification is discarded.
- Button held through reset release: the block re-qualifies from IDLE_LO. btn_rise fires STABLE_COUNT+3 edges after release, so a single press always yields exactly one btn_rise.
- STABLE_COUNT=1: WAIT_x lasts one cycle, giving a total latency of 4 edges.

Decomposition:
- Shared include (debounce_defs.vh):
  - State encodings IDLE_LO=2'd0, WAIT_HI=2'd1, IDLE_HI=2'd2, WAIT_LO=2'd3.
  - Default STABLE_COUNT for the 100 MHz board clock.
- Sub-module sync_2ff:
  - Generic 2-flop synchronizer with ports clk, reset, d, q; async active-high reset to 0.
  - Reused for other board inputs.

Test Plan (bench uses STABLE_COUNT=4, ACTIVE_LOW=1, 10 ns clk):
1. Reset: assert reset mid-cycle with btn_in=0 → btn_level, btn_rise and btn_fall go 0 before the next clk edge; they stay 0 while reset is held.
2. Clean press: release reset with btn_in=1; set btn_in=0 before edge E1 and hold → btn_level=1 and btn_rise=1 at E7; btn_rise=0 at E8; btn_fall stays 0 throughout.
3. Bounce: btn_in toggles 0/1 every 2 cycles for 10 cycles, then holds 0 → no strobe during bouncing; btn_level rises exactly 7 edges after the final transition, with one btn_rise pulse.
4. Glitch: from pressed steady state, btn_in=1 for 3 cycles, then back to 0 → btn_level stays 1 and btn_fall is never asserted.
5. Release: from pressed, btn_in=1 held → btn_level=0 with one-cycle btn_fall at E7; no btn_rise.
6. Reset during WAIT_HI, button held: pulse reset at E4 of a press → outputs 0 immediately; after release, btn_rise fires at the 7th edge and fires only once.
